// File: rtl/tx_module_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_module_if
// Description : Upstream request channel (valid/ready handshake plus payload)
//               feeding the tx_module dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_module_if #(
    parameter int A_WIDTH = 8,
    parameter int W_WIDTH = 8
);
    logic               req_valid;
    logic               req_ready;
    logic [7:0]         req_op_id;
    logic [A_WIDTH-1:0] req_addr;
    logic               req_wr;
    logic [W_WIDTH-1:0] req_wr_data;

    // Request source
    modport master (
        output req_valid, req_op_id, req_addr, req_wr, req_wr_data,
        input  req_ready
    );

    // Request sink (the dispatcher)
    modport slave (
        input  req_valid, req_op_id, req_addr, req_wr, req_wr_data,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/tx_module.sv
`default_nettype none
// ============================================================================
// Module      : tx_module
// Description : Buffers requests in a 4-deep FIFO and dispatches each one to
//               its target switch instance once that instance is not busy.
//               Invalid targets and busy timeouts are reported as errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_module #(
    parameter int NUM_SW_INST = 5,
    parameter int A_WIDTH     = 8,
    parameter int W_WIDTH     = 8,
    parameter int TIMEOUT     = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    tx_module_if.slave                  req,
    input  wire logic [NUM_SW_INST-1:0] sw_busy,
    output logic      [NUM_SW_INST-1:0] sel_en,
    output logic      [7:0]             op_id,
    output logic      [A_WIDTH-4:0]     addr_out,
    output logic                        wr_en,
    output logic      [W_WIDTH-1:0]     wr_data,
    output logic                        err_valid,
    output logic      [1:0]             err_code,
    output logic      [7:0]             err_op_id
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         op_mem_q   [4];
    logic [A_WIDTH-1:0] addr_mem_q [4];
    logic               wr_mem_q   [4];
    logic [W_WIDTH-1:0] data_mem_q [4];
    logic [1:0]         wr_ptr_q;
    logic [1:0]         rd_ptr_q;
    logic [2:0]         count_q;
    logic               full;
    logic               push;
    logic               pop;

    // FSM state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Head-of-FIFO decode
    logic [2:0]         head_idx;
    logic               head_busy;
    logic               head_invalid;

    // Next values of the registered outputs
    logic [NUM_SW_INST-1:0] sel_en_d;
    logic [7:0]             op_id_d;
    logic [A_WIDTH-4:0]     addr_out_d;
    logic                   wr_en_d;
    logic [W_WIDTH-1:0]     wr_data_d;
    logic                   err_valid_d;
    logic [1:0]             err_code_d;
    logic [7:0]             err_op_id_d;

    // Ready is held low during reset as well as when full; a same-cycle pop
    // does not open a slot.
    assign full          = (count_q == 3'd4);
    assign req.req_ready = ~full & ~rst;
    assign push          = req.req_valid & ~full & ~rst;

    assign head_idx     = addr_mem_q[rd_ptr_q][A_WIDTH-1:A_WIDTH-3];
    assign head_invalid = ({1'b0, head_idx} >= 4'(NUM_SW_INST));

    // Busy flag of the head's target, looked up only over legal indices
    always_comb begin
        head_busy = 1'b0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (head_idx == 3'(i)) begin
                head_busy = sw_busy[i];
            end
        end
    end

    // FIFO payload write on accept; payload needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]   <= req.req_op_id;
            addr_mem_q[wr_ptr_q] <= req.req_addr;
            wr_mem_q[wr_ptr_q]   <= req.req_wr;
            data_mem_q[wr_ptr_q] <= req.req_wr_data;
        end
    end

    // FIFO pointers and occupancy; 2-bit pointers wrap modulo 4 naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // FSM state and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and strobe generation; strobes default to zero so
    // every payload output reads 0 outside its strobe cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        sel_en_d    = '0;
        op_id_d     = '0;
        addr_out_d  = '0;
        wr_en_d     = 1'b0;
        wr_data_d   = '0;
        err_valid_d = 1'b0;
        err_code_d  = 2'b00;
        err_op_id_d = '0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 3'd0) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                if (head_invalid) begin
                    pop         = 1'b1;
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b01;
                    err_op_id_d = op_mem_q[rd_ptr_q];
                    state_d     = S_IDLE;
                end else if (!head_busy) begin
                    pop        = 1'b1;
                    for (int i = 0; i < NUM_SW_INST; i++) begin
                        sel_en_d[i] = (head_idx == 3'(i));
                    end
                    op_id_d    = op_mem_q[rd_ptr_q];
                    addr_out_d = addr_mem_q[rd_ptr_q][A_WIDTH-4:0];
                    wr_en_d    = wr_mem_q[rd_ptr_q];
                    wr_data_d  = data_mem_q[rd_ptr_q];
                    state_d    = S_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    pop         = 1'b1;
                    err_valid_d = 1'b1;
                    err_code_d  = 2'b10;
                    err_op_id_d = op_mem_q[rd_ptr_q];
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Gives the receive path a cycle to raise sw_busy
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered dispatch and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_en    <= '0;
            op_id     <= '0;
            addr_out  <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'b00;
            err_op_id <= '0;
        end else begin
            sel_en    <= sel_en_d;
            op_id     <= op_id_d;
            addr_out  <= addr_out_d;
            wr_en     <= wr_en_d;
            wr_data   <= wr_data_d;
            err_valid <= err_valid_d;
            err_code  <= err_code_d;
            err_op_id <= err_op_id_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tx_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_module
// Description : Directed self-checking bench for tx_module with a scoreboard
//               of expected dispatch/error events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_module;
    localparam int NUM = 5;
    localparam int AW  = 8;
    localparam int WW  = 8;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_module_if #(.A_WIDTH(AW), .W_WIDTH(WW)) bus ();

    logic [NUM-1:0] sw_busy;
    logic [NUM-1:0] sel_en;
    logic [7:0]     op_id;
    logic [AW-4:0]  addr_out;
    logic           wr_en;
    logic [WW-1:0]  wr_data;
    logic           err_valid;
    logic [1:0]     err_code;
    logic [7:0]     err_op_id;

    tx_module #(.NUM_SW_INST(NUM), .A_WIDTH(AW), .W_WIDTH(WW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.slave),
        .sw_busy   (sw_busy),
        .sel_en    (sel_en),
        .op_id     (op_id),
        .addr_out  (addr_out),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_op_id (err_op_id)
    );

    typedef struct {
        bit           is_err;
        logic [1:0]   code;
        logic [7:0]   err_op;
        logic [NUM-1:0] sel;
        logic [7:0]   op;
        logic [AW-4:0] addr;
        logic         wr;
        logic [WW-1:0] data;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request from a negedge; returns at the negedge after the
    // accept edge. acc is the cycle number the accept edge produces.
    task automatic push(input logic [7:0] op, input logic [7:0] a, input logic w,
                        input logic [7:0] d, input bit expect_evt, input bit tmo,
                        input int delay, output int acc);
        int   n;
        exp_t e;
        logic [2:0] idx;
        n = 0;
        bus.req_valid   = 1'b1;
        bus.req_op_id   = op;
        bus.req_addr    = a;
        bus.req_wr      = w;
        bus.req_wr_data = d;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 100), 64'd1);
        acc = cyc + 1;
        if (expect_evt) begin
            idx      = a[7:5];
            e.is_err = (int'(idx) >= NUM) || tmo;
            e.code   = (int'(idx) >= NUM) ? 2'b01 : 2'b10;
            e.err_op = e.is_err ? op : 8'h00;
            e.sel    = e.is_err ? '0 : (NUM'(1) << idx);
            e.op     = e.is_err ? 8'h00 : op;
            e.addr   = e.is_err ? '0 : a[4:0];
            e.wr     = e.is_err ? 1'b0 : w;
            e.data   = e.is_err ? 8'h00 : d;
            e.cyc    = (delay >= 0) ? acc + delay : -1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drop();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (sel_en !== '0 || err_valid !== 1'b0) begin
            chk("strobe_exclusive", 64'(sel_en != '0 && err_valid), 64'd0);
            chk("event_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sel_en", 64'(sel_en), 64'(e.sel));
                chk("err_valid", 64'(err_valid), 64'(e.is_err));
                chk("disp_fields", 64'({op_id, addr_out, wr_en, wr_data}),
                    64'({e.op, e.addr, e.wr, e.data}));
                chk("err_op_id", 64'(err_op_id), 64'(e.err_op));
                if (e.is_err) chk("err_code", 64'(err_code), 64'(e.code));
                if (e.cyc >= 0) chk("event_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("idle_zero", 64'({op_id, addr_out, wr_en, wr_data, err_op_id}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int r;
        bus.req_valid   = 1'b0;
        bus.req_op_id   = 8'h00;
        bus.req_addr    = '0;
        bus.req_wr      = 1'b0;
        bus.req_wr_data = '0;
        sw_busy         = '0;
        rst             = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_outputs", 64'({sel_en, op_id, addr_out, wr_en, wr_data,
                                err_valid, err_code, err_op_id}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // Basic write dispatch, 2-edge latency
        push(8'h11, 8'h25, 1'b1, 8'hA5, 1'b1, 1'b0, 2, acc);
        drop();
        drain("drain_write");

        // Invalid target index 7
        push(8'h22, 8'hE0, 1'b0, 8'h00, 1'b1, 1'b0, 2, acc);
        drop();
        drain("drain_invalid7");

        // Boundary: index 5 is first invalid, index 4 is last valid (read)
        push(8'h23, 8'hA3, 1'b1, 8'h44, 1'b1, 1'b0, 2, acc);
        drop();
        drain("drain_invalid5");
        push(8'h5A, 8'h9F, 1'b0, 8'h3C, 1'b1, 1'b0, 2, acc);
        drop();
        drain("drain_read4");

        // Busy timeout after exactly 16 CHECK cycles
        sw_busy = 5'b00100;
        push(8'h33, 8'h40, 1'b1, 8'h77, 1'b1, 1'b1, 17, acc);
        drop();
        drain("drain_timeout");
        sw_busy = '0;
        @(negedge clk);

        // Backpressure: 4 accepted while all busy, 5th refused
        sw_busy = '1;
        push(8'h41, 8'h01, 1'b1, 8'hB1, 1'b1, 1'b0, -1, acc);
        push(8'h42, 8'h22, 1'b0, 8'hB2, 1'b1, 1'b0, -1, acc);
        push(8'h43, 8'h43, 1'b1, 8'hB3, 1'b1, 1'b0, -1, acc);
        push(8'h44, 8'h64, 1'b1, 8'hB4, 1'b1, 1'b0, -1, acc);
        bus.req_op_id   = 8'h45;
        bus.req_addr    = 8'h85;
        bus.req_wr_data = 8'hB5;
        chk("full_ready0_a", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("full_ready0_b", 64'(bus.req_ready), 64'd0);
        drop();
        r = cyc;
        for (int i = 0; i < 4; i++) sb[i].cyc = r + 1 + 3 * i;
        sw_busy = '0;
        drain("drain_backpressure");

        // Reset with 3 requests buffered: no strobes, FIFO emptied
        sw_busy = '1;
        push(8'h51, 8'h01, 1'b1, 8'hC1, 1'b0, 1'b0, -1, acc);
        push(8'h52, 8'h21, 1'b1, 8'hC2, 1'b0, 1'b0, -1, acc);
        push(8'h53, 8'h41, 1'b1, 8'hC3, 1'b0, 1'b0, -1, acc);
        drop();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        sw_busy = '0;
        @(negedge clk);
        chk("postrst_ready", 64'(bus.req_ready), 64'd1);
        repeat (10) @(negedge clk);
        push(8'h61, 8'h63, 1'b0, 8'hD1, 1'b1, 1'b0, 2, acc);
        drop();
        drain("drain_postrst");

        // Busy for 5 cycles then cleared: dispatch in first free CHECK cycle
        sw_busy = 5'b00010;
        push(8'h77, 8'h2A, 1'b1, 8'h99, 1'b1, 1'b0, 6, acc);
        drop();
        repeat (5) @(negedge clk);
        sw_busy = '0;
        drain("drain_busyclear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
